// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling default and mid-bit sample point.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  // Tick index (0-based) at which a bit is sampled, counted from the bit's first tick.
  function automatic int mid_sample(input int oversample);
    return oversample / 2 - 1;
  endfunction

  localparam int MID_SAMPLE = mid_sample(OVERSAMPLE_DEF);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to RST_VAL.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver, LSB first, one stop bit.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud16x_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 framing_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] MID      = CNT_W'(mid_sample(OVERSAMPLE));
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic rx_s;
  logic prev_q;

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d;
  logic                 par_bad_q, par_bad_d;
`endif

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx_in),
    .q_o (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      prev_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      prev_q    <= rx_s;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      // Edge detect runs every clk; a line held low (break) never re-triggers.
      IDLE: begin
        if (!rx_s && prev_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (baud16x_tick) begin
          if (cnt_q == MID) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (baud16x_tick) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + BIT_W'(1);
            if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud16x_tick) begin
          if (cnt_q == LAST) begin
            cnt_d     = '0;
            par_bad_d = (^shift_q) ^ rx_s;
            state_d   = STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`endif
      STOP: begin
        if (baud16x_tick) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
            if (!rx_s) begin
              ferr_d = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            else if (par_bad_q) begin
              perr_d = 1'b1;
            end
`endif
            else begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign framing_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = perr_q;
`endif
  assign rx_busy     = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (5..8).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, baud16x ticks per bit period.
REQ-003 SHALL have port clk, input, 1, system clock; one clock domain only.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port baud16x_tick, input, 1, one-clk-wide enable pulse at 16x baud, driven by the baud generator's baud16x_out.
REQ-006 SHALL have port rx_in, input, 1, asynchronous serial line; idles high.
REQ-007 SHALL have port rx_data, output, DATA_BITS, last good received word.
REQ-008 SHALL have port rx_valid, output, 1, one-clk pulse when rx_data updates.
REQ-009 SHALL have port framing_err, output, 1, one-clk pulse when the stop bit samples low.
REQ-010 SHALL have port rx_busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-011 SHALL pass rx_in through a 2-flop synchronizer (rx_s), and SHALL treat every later reference to the line as rx_s.
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY (PARITY_EN only), STOP.
REQ-013 SHALL advance the tick counter and FSM only on clk cycles with baud16x_tick=1, except the IDLE falling-edge detect; with no ticks, all state SHALL hold.
REQ-014 In IDLE, SHALL go to START with tick counter 0 when rx_s is 0 and its previous sampled value was 1.
REQ-015 In START, SHALL sample rx_s on the 8th tick (counter=OVERSAMPLE/2-1): 0 -> DATA with counter cleared; 1 -> IDLE as a false start, with no outputs pulsed.
REQ-016 In DATA, SHALL sample every OVERSAMPLE ticks at mid-bit, shift in LSB first, and leave after DATA_BITS samples.
REQ-017 In STOP, at mid-bit, SHALL return to IDLE; rx_s=1 SHALL load rx_data and pulse rx_valid; rx_s=0 SHALL pulse framing_err and leave rx_data unchanged.
REQ-018 rx_valid/framing_err SHALL assert on the clk cycle after the deciding tick, for exactly one clk.
REQ-019 rx_valid and framing_err SHALL never assert in the same cycle.
REQ-020 After a framing error with the line held low (break), SHALL not restart until rx_s has returned to 1 (edge rule in REQ-014).
REQ-021 rx_data SHALL hold until the next good frame; no consumer handshake; overrun is the consumer's responsibility.

Reset
REQ-022 On rst=1, SHALL force IDLE; clear counters and the shift register; set rx_data=0, rx_valid=0, framing_err=0, rx_busy=0, parity_err=0; preset synchronizer flops and previous-sample flop to 1.
REQ-023 Reset mid-frame SHALL discard the partial frame with no pulse; the next frame SHALL be received normally.

Configuration
REQ-024 With macro UART_RX_PARITY_EN defined, SHALL add output parity_err (1 bit) and the PARITY state between DATA and STOP, sampling one even-parity bit.
REQ-025 On a parity mismatch, SHALL pulse parity_err at the STOP decision instead of rx_valid, and leave rx_data unchanged; a framing error takes priority.
REQ-026 Without UART_RX_PARITY_EN, the parity_err port and PARITY state SHALL not exist, and the frame SHALL be 8N1.

Structure
REQ-027 SHALL place the FSM state typedef, OVERSAMPLE default, and MID_SAMPLE constant in shared package uart_pkg, reused by the future uart_tx.
REQ-028 SHALL implement the synchronizer as sub-module uart_sync (2-flop, reset value parameterized).

Verification
REQ-029 Bench SHALL send 0xA5 as 8N1 with the tick every 48 clk -> rx_data=0xA5, rx_valid high for 1 clk, one cycle after tick 152 following the start edge.
REQ-030 Bench SHALL send a 0x3C frame with the stop bit low -> framing_err pulses once, rx_valid stays 0, rx_data keeps its prior value.
REQ-031 Bench SHALL apply a 4-tick low glitch on an idle line -> return to IDLE, no pulses, rx_busy high for at most 8 ticks.
REQ-032 Bench SHALL assert rst during data bit 3 of a frame, then send 0x5A -> no pulse from the aborted frame; 0x5A is received correctly.
REQ-033 Bench SHALL send 0x00 followed by a 20-bit break -> one framing_err pulse, then receive a later 0xFF frame only after the line returns high.
REQ-034 With UART_RX_PARITY_EN, bench SHALL send 0x07 with parity=0 -> parity_err pulses; with parity=1 -> rx_valid, rx_data=0x07, with the stop decision at tick 168.
